// File: rtl/proc_ctrl_fsm_if.sv
// Control/datapath bundle between the instruction source and the 3-bit processor sequencer.
// The master drives run/din; the slave (sequencer) drives every datapath enable.
interface proc_ctrl_fsm_if;
  logic       run;
  logic [8:0] din;
  logic [7:0] r_in;
  logic [3:0] bus_sel;
  logic       a_in;
  logic       g_in;
  logic       addsub;
  logic       xor_enable;
  logic       done;
  logic       busy;

  modport master (
    output run, din,
    input  r_in, bus_sel, a_in, g_in, addsub, xor_enable, done, busy
  );

  modport slave (
    input  run, din,
    output r_in, bus_sel, a_in, g_in, addsub, xor_enable, done, busy
  );
endinterface

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle sequencer: latches an instruction in T0 and walks T1..T3 driving datapath enables.
// Latency run->done: 2 cycles (mv/mvi/illegal), 4 cycles (sub/xor); run is ignored while busy.
module proc_ctrl_fsm (
  input  logic             clk,
  input  logic             resetn,
  proc_ctrl_fsm_if.slave   ctl
);
  localparam int NREG = 8;
  localparam int IW   = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [3:0] SEL_G    = 4'd8;
  localparam logic [3:0] SEL_DIN  = 4'd9;
  localparam logic [3:0] SEL_NONE = 4'd10;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ir;
  logic [2:0]      op;
  logic [2:0]      rx;
  logic [2:0]      ry;
  logic [NREG-1:0] rx_hot;

  logic [NREG-1:0] r_in;
  logic [3:0]      bus_sel;
  logic            a_in;
  logic            g_in;
  logic            addsub;
  logic            xor_enable;
  logic            done;
  logic            busy;

  assign op     = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];
  assign rx_hot = NREG'(1) << rx;

  // IR only loads on the fetch edge, so din/run activity while busy cannot corrupt it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == T0 && ctl.run) begin
        ir <= ctl.din;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    r_in       = '0;
    bus_sel    = SEL_NONE;
    a_in       = 1'b0;
    g_in       = 1'b0;
    addsub     = 1'b0;
    xor_enable = 1'b0;
    done       = 1'b0;
    busy       = (state != T0);

    case (state)
      T0: begin
        if (ctl.run) begin
          state_nxt = T1;
        end
      end
      T1: begin
        case (op)
          OP_MV: begin
            bus_sel   = {1'b0, ry};
            r_in      = rx_hot;
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_MVI: begin
            bus_sel   = SEL_DIN;
            r_in      = rx_hot;
            done      = 1'b1;
            state_nxt = T0;
          end
          OP_SUB, OP_XOR: begin
            bus_sel   = {1'b0, rx};
            a_in      = 1'b1;
            state_nxt = T2;
          end
          default: begin
            // Illegal opcode retires as a NOP: no enables, just the completion pulse.
            done      = 1'b1;
            state_nxt = T0;
          end
        endcase
      end
      T2: begin
        bus_sel    = {1'b0, ry};
        g_in       = 1'b1;
        addsub     = (op == OP_SUB);
        xor_enable = (op == OP_XOR);
        state_nxt  = T3;
      end
      T3: begin
        bus_sel   = SEL_G;
        r_in      = rx_hot;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: begin
        state_nxt = T0;
      end
    endcase
  end

  assign ctl.r_in       = r_in;
  assign ctl.bus_sel    = bus_sel;
  assign ctl.a_in       = a_in;
  assign ctl.g_in       = g_in;
  assign ctl.addsub     = addsub;
  assign ctl.xor_enable = xor_enable;
  assign ctl.done       = done;
  assign ctl.busy       = busy;
endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: per-instruction expected-output queue plus literal spot checks.
module tb_proc_ctrl_fsm;
  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  proc_ctrl_fsm_if cpu ();

  proc_ctrl_fsm dut (
    .clk    (clk),
    .resetn (resetn),
    .ctl    (cpu.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r_in;
    logic [3:0] bus_sel;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       xor_enable;
    logic       done;
    logic       busy;
  } outs_t;

  outs_t exp_q[$];

  function automatic outs_t mk(logic [7:0] r, logic [3:0] s, logic a, logic g,
                               logic as, logic xe, logic d);
    outs_t o;
    o.r_in = r; o.bus_sel = s; o.a_in = a; o.g_in = g;
    o.addsub = as; o.xor_enable = xe; o.done = d; o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t idle_outs();
    outs_t o;
    o = '0;
    o.bus_sel = 4'd10;
    return o;
  endfunction

  // Per-cycle output schedule of one instruction, written straight from the opcode table.
  task automatic schedule(input logic [8:0] w);
    int         opc, x, y;
    logic [7:0] hot;
    opc = int'(w[8:6]);
    x   = int'(w[5:3]);
    y   = int'(w[2:0]);
    hot = 8'(2 ** x);
    if (opc == 0) begin
      exp_q.push_back(mk(hot, 4'(y), 0, 0, 0, 0, 1));
    end else if (opc == 1) begin
      exp_q.push_back(mk(hot, 4'd9, 0, 0, 0, 0, 1));
    end else if (opc == 2 || opc == 4) begin
      exp_q.push_back(mk(8'd0, 4'(x), 1, 0, 0, 0, 0));
      exp_q.push_back(mk(8'd0, 4'(y), 0, 1, opc == 2, opc == 4, 0));
      exp_q.push_back(mk(hot, 4'd8, 0, 0, 0, 0, 1));
    end else begin
      exp_q.push_back(mk(8'd0, 4'd10, 0, 0, 0, 0, 1));
    end
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (cpu.run) begin
      schedule(cpu.din);
    end
  end

  outs_t dut_o;
  assign dut_o = '{cpu.r_in, cpu.bus_sel, cpu.a_in, cpu.g_in,
                   cpu.addsub, cpu.xor_enable, cpu.done, cpu.busy};

  logic prev_done = 1'b0;

  always @(negedge clk) begin
    outs_t e;
    e = (exp_q.size() != 0) ? exp_q[0] : idle_outs();
    total++;
    if (dut_o !== e) begin
      bad++;
      $display("FAIL model t=%0t got r_in=%b sel=%0d a=%b g=%b as=%b xe=%b done=%b busy=%b want r_in=%b sel=%0d a=%b g=%b as=%b xe=%b done=%b busy=%b",
               $time, dut_o.r_in, dut_o.bus_sel, dut_o.a_in, dut_o.g_in, dut_o.addsub,
               dut_o.xor_enable, dut_o.done, dut_o.busy, e.r_in, e.bus_sel, e.a_in,
               e.g_in, e.addsub, e.xor_enable, e.done, e.busy);
    end
    total++;
    if ((prev_done && cpu.done) || $countones(cpu.r_in) > 1 ||
        (int'(cpu.a_in) + int'(cpu.g_in) + int'(cpu.r_in != 0)) > 1) begin
      bad++;
      $display("FAIL invariant t=%0t got done=%b prev_done=%b r_in=%b a=%b g=%b want exclusive enables",
               $time, cpu.done, prev_done, cpu.r_in, cpu.a_in, cpu.g_in);
    end
    prev_done = cpu.done;
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Sets inputs just after the next rising edge; they hold for that whole cycle.
  task automatic step(input logic r, input logic [8:0] d);
    @(posedge clk);
    #1;
    cpu.run = r;
    cpu.din = d;
  endtask

  initial begin
    resetn  = 1'b0;
    cpu.run = 1'b0;
    cpu.din = '0;
    #2;
    lit("rst_sel", 32'(cpu.bus_sel), 32'd10);
    lit("rst_busy", 32'(cpu.busy), 32'd0);
    lit("rst_rin", 32'(cpu.r_in), 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // mvi R3, imm
    step(1, 9'b001_011_000);
    step(0, 9'b000_000_101); #2;
    lit("mvi_sel", 32'(cpu.bus_sel), 32'd9);
    lit("mvi_rin", 32'(cpu.r_in), 32'h08);
    lit("mvi_done", 32'(cpu.done), 32'd1);
    step(0, '0); #2;
    lit("mvi_busy_fall", 32'(cpu.busy), 32'd0);

    // mv R1, R3
    step(1, 9'b000_001_011);
    step(0, '0); #2;
    lit("mv_sel", 32'(cpu.bus_sel), 32'd3);
    lit("mv_rin", 32'(cpu.r_in), 32'h02);
    lit("mv_done", 32'(cpu.done), 32'd1);
    step(0, '0);

    // sub R5, R6
    step(1, 9'b010_101_110);
    step(0, '0); #2;
    lit("sub_t1_sel", 32'(cpu.bus_sel), 32'd5);
    lit("sub_t1_a", 32'(cpu.a_in), 32'd1);
    step(0, '0); #2;
    lit("sub_t2_sel", 32'(cpu.bus_sel), 32'd6);
    lit("sub_t2_alu", {30'd0, cpu.addsub, cpu.xor_enable}, 32'b10);
    lit("sub_t2_g", 32'(cpu.g_in), 32'd1);
    step(0, '0); #2;
    lit("sub_t3_sel", 32'(cpu.bus_sel), 32'd8);
    lit("sub_t3_rin", 32'(cpu.r_in), 32'h20);
    step(0, '0);

    // xor R0,R7 then mv R2,R1 then sub R2,R2, run held high throughout
    step(1, 9'b100_000_111);
    step(1, 9'b111_111_111);
    step(1, 9'b111_111_111); #2;
    lit("xor_t2_alu", {30'd0, cpu.addsub, cpu.xor_enable}, 32'b01);
    step(1, 9'b111_111_111); #2;
    lit("xor_t3_rin", 32'(cpu.r_in), 32'h01);
    step(1, 9'b000_010_001);
    step(1, 9'b010_010_010); #2;
    lit("b2b_mv_rin", 32'(cpu.r_in), 32'h04);
    lit("b2b_mv_done", 32'(cpu.done), 32'd1);
    step(1, 9'b010_010_010);
    step(0, '0); #2;
    lit("rxry_t1_sel", 32'(cpu.bus_sel), 32'd2);
    step(0, '0); #2;
    lit("rxry_t2_sel", 32'(cpu.bus_sel), 32'd2);
    step(0, '0);
    step(0, '0);

    // illegal 111_010_001
    step(1, 9'b111_010_001);
    step(0, '0); #2;
    lit("ill_rin", 32'(cpu.r_in), 32'd0);
    lit("ill_a", 32'(cpu.a_in), 32'd0);
    lit("ill_done", 32'(cpu.done), 32'd1);
    step(0, '0); #2;
    lit("ill_busy", 32'(cpu.busy), 32'd0);

    // reset during T2 of sub R3,R4
    step(1, 9'b010_011_100);
    step(0, '0);
    step(0, '0); #2;
    lit("rmid_g_before", 32'(cpu.g_in), 32'd1);
    resetn = 1'b0;
    #1;
    lit("rmid_g_after", 32'(cpu.g_in), 32'd0);
    lit("rmid_busy", 32'(cpu.busy), 32'd0);
    lit("rmid_sel", 32'(cpu.bus_sel), 32'd10);
    @(posedge clk);
    #1 resetn = 1'b1;
    #2;
    lit("rmid_done", 32'(cpu.done), 32'd0);
    lit("rmid_rin", 32'(cpu.r_in), 32'd0);

    // run/din toggling while busy must not disturb IR (xor R1,R6)
    step(1, 9'b100_001_110);
    step(1, 9'b000_111_000);
    step(0, 9'b001_100_000);
    step(1, 9'b001_100_000); #2;
    lit("tog_t3_rin", 32'(cpu.r_in), 32'h02);
    lit("tog_t3_sel", 32'(cpu.bus_sel), 32'd8);
    step(0, '0);
    repeat (3) step(0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
